overlay_mem_arbiter: RTL and testbench

- Shares the single SDRAM port between two requesters: the overlay download stream (byte writes from the HPS ioctl path) and the per-pixel overlay fetch (sequential 16-bit RGBA reads).
- Reads are prefetched into a small FIFO so that the pixel side sees one word per pixel-enable with no SDRAM latency.
- Sits between hps_io/video timing and the sdram controller in the 48 MHz overlay domain, and replaces the ad-hoc pic_req/pic_addr logic.

---
 rtl/overlay_pkg.sv | 25 ++
 rtl/overlay_mem_arbiter_if.sv | 32 +++
 rtl/overlay_prefetch_fifo.sv | 62 ++++++
 rtl/overlay_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_overlay_mem_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/overlay_pkg.sv
// Shared types and constants for the overlay SDRAM arbiter slice.
//   state_e      : arbiter FSM states
//   ADDR_W/PIX_W : SDRAM byte-address width and overlay pixel word width
//   ADDR_STEP    : byte step between consecutive 16-bit pixel words
package overlay_pkg;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned PIX_W  = 16;

  localparam logic [ADDR_W-1:0] ADDR_STEP = 25'd2;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StGap,
    StBusy
  } state_e;

  function automatic logic [ADDR_W-1:0] next_rd_addr(input logic [ADDR_W-1:0] addr);
    // Natural 25-bit overflow gives the modulo-2^25 wrap.
    return addr + ADDR_STEP;
  endfunction

endpackage

// File: rtl/overlay_mem_arbiter_if.sv
// SDRAM-side bus of the overlay arbiter.
//   master : arbiter side (drives address, write byte and strobes)
//   slave  : SDRAM controller side (drives read word and ready)
interface overlay_mem_arbiter_if;
  import overlay_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_we;
  logic              mem_rd;
  logic [PIX_W-1:0]  mem_dout;
  logic              mem_ready;

  modport master (
    output mem_addr,
    output mem_din,
    output mem_we,
    output mem_rd,
    input  mem_dout,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_din,
    input  mem_we,
    input  mem_rd,
    output mem_dout,
    output mem_ready
  );

endinterface

// File: rtl/overlay_prefetch_fifo.sv
// Synchronous prefetch FIFO with first-word-fall-through head.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   flush        : empties the FIFO; wins over push and pop
//   push/push_data, pop : write/read requests (pop ignored when empty)
//   head         : current front word (valid when empty=0)
//   count        : occupancy, 0..Depth
//   empty        : no words stored
module overlay_prefetch_fifo
  import overlay_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [PIX_W-1:0] push_data,
  input  logic             pop,
  output logic [PIX_W-1:0] head,
  output logic [PtrW:0]    count,
  output logic             empty
);

  logic [PIX_W-1:0] storage_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW+1)'(Depth));
  assign do_pop  = pop & ~empty;
  // A full FIFO can still accept a word in the cycle its head leaves.
  assign do_push = push & (~full | do_pop);
  assign head    = storage_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) storage_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/overlay_mem_arbiter.sv
// Overlay SDRAM arbiter: shares one SDRAM port between the download byte-write stream and
// the sequential per-pixel overlay fetch, prefetching reads into a small FIFO.
//   clock, reset           : overlay clock, asynchronous active-high reset
//   dl_active/dl_wr/dl_addr/dl_data, dl_wait : download write path and its stall
//   frame_start            : VSync pulse; flushes the prefetch and restarts at BASE_ADDR
//   pix_ce/pix_active      : pixel enable and visible-area flag
//   pix_data               : overlay word for the current pixel
//   underrun/overflow      : sticky error flags
//   mem                    : SDRAM bus (master side)
module overlay_mem_arbiter
  import overlay_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dl_active,
  input  logic                  dl_wr,
  input  logic [ADDR_W-1:0]     dl_addr,
  input  logic [7:0]            dl_data,
  output logic                  dl_wait,
  input  logic                  frame_start,
  input  logic                  pix_ce,
  input  logic                  pix_active,
  output logic [PIX_W-1:0]      pix_data,
  output logic                  underrun,
  output logic                  overflow,
  overlay_mem_arbiter_if.master mem
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic              start_wr, start_rd;
  logic              op_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_din_q;

  logic              wr_full_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              overflow_q;

  logic [ADDR_W-1:0] rd_addr_q;
  logic              epoch_q, rd_epoch_q;
  logic              pf_en_q;
  logic              dl_active_q;

  logic [PIX_W-1:0]  pix_data_q;
  logic              underrun_q;

  logic              dl_rise, flush, done, inflight, can_prefetch;
  logic              push, pop, pix_take;
  logic              fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [PIX_W-1:0]  fifo_head;

  assign dl_rise  = dl_active & ~dl_active_q;
  assign flush    = frame_start | dl_rise;
  assign done     = (state_q == StBusy) & mem.mem_ready;
  assign inflight = op_rd_q & (state_q != StIdle);
  // Never issue in a flush cycle: that read would be tagged with the dying epoch.
  assign can_prefetch = pf_en_q & ~dl_active & ~flush &
                        ((32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH);
  assign push     = done & op_rd_q & (rd_epoch_q == epoch_q) & ~flush;
  assign pix_take = pix_ce & pix_active & ~dl_active & ~flush;
  assign pop      = pix_take & ~fifo_empty;

  overlay_prefetch_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .push     (push),
    .push_data(mem.mem_dout),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    start_wr = 1'b0;
    start_rd = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem.mem_ready) begin
          if (wr_full_q) begin
            state_d  = StWr;
            start_wr = 1'b1;
          end else if (can_prefetch) begin
            state_d  = StRd;
            start_rd = 1'b1;
          end
        end
      end
      StWr, StRd: state_d = StGap;
      // The controller drops ready only after seeing the strobe, so skip one cycle.
      StGap:      state_d = StBusy;
      StBusy:     if (mem.mem_ready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      op_rd_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_wr) begin
        op_rd_q    <= 1'b0;
        mem_addr_q <= wr_addr_q;
        mem_din_q  <= wr_data_q;
      end else if (start_rd) begin
        op_rd_q    <= 1'b1;
        mem_addr_q <= rd_addr_q;
      end
    end
  end

  // Download holding register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_full_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (dl_wr && !wr_full_q) begin
        wr_full_q <= 1'b1;
        wr_addr_q <= dl_addr;
        wr_data_q <= dl_data;
      end else if (done && !op_rd_q) begin
        wr_full_q <= 1'b0;
      end
      if (dl_wr && wr_full_q) overflow_q <= 1'b1;
    end
  end

  // Prefetch address, epoch tagging and enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_addr_q   <= BASE_ADDR;
      epoch_q     <= 1'b0;
      rd_epoch_q  <= 1'b0;
      pf_en_q     <= 1'b0;
      dl_active_q <= 1'b0;
    end else begin
      dl_active_q <= dl_active;
      if (flush) begin
        rd_addr_q <= BASE_ADDR;
        epoch_q   <= ~epoch_q;
      end else if (start_rd) begin
        rd_addr_q <= next_rd_addr(rd_addr_q);
      end
      if (start_rd) rd_epoch_q <= epoch_q;
      if (dl_active)        pf_en_q <= 1'b0;
      else if (frame_start) pf_en_q <= 1'b1;
    end
  end

  // Pixel side.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_data_q <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (pix_ce) pix_data_q <= pop ? fifo_head : '0;
      if (pix_take && fifo_empty) underrun_q <= 1'b1;
    end
  end

  assign dl_wait      = wr_full_q;
  assign overflow     = overflow_q;
  assign underrun     = underrun_q;
  assign pix_data     = pix_data_q;
  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_din  = mem_din_q;
  assign mem.mem_we   = (state_q == StWr);
  assign mem.mem_rd   = (state_q == StRd);

endmodule

// File: tb/tb_overlay_mem_arbiter.sv
// Self-checking bench for overlay_mem_arbiter with a latency-programmable SDRAM model.
module tb_overlay_mem_arbiter;
  import overlay_pkg::*;

  localparam int unsigned       FifoDepth = 8;
  localparam logic [ADDR_W-1:0] BaseAddr  = '0;

  logic              clock = 1'b0;
  logic              reset;
  logic              dl_active, dl_wr, dl_wait;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic              frame_start, pix_ce, pix_active;
  logic [PIX_W-1:0]  pix_data;
  logic              underrun, overflow;

  overlay_mem_arbiter_if bus ();

  overlay_mem_arbiter #(
    .FIFO_DEPTH(FifoDepth),
    .BASE_ADDR (BaseAddr)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .dl_active  (dl_active),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .dl_wait    (dl_wait),
    .frame_start(frame_start),
    .pix_ce     (pix_ce),
    .pix_active (pix_active),
    .pix_data   (pix_data),
    .underrun   (underrun),
    .overflow   (overflow),
    .mem        (bus.master)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // SDRAM model: ready drops after a strobe, returns mem_lat negedges later; read word = addr/2.
  int                mem_lat = 3;
  int                lat_cnt;
  logic              busy_m;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] rd_log [$];
  logic [ADDR_W+7:0] wr_log [$];
  int                rd_during_dl = 0;

  logic [PIX_W-1:0]  exp_pix [$];
  logic [ADDR_W+7:0] exp_wr  [$];

  always @(negedge clock) begin
    if (reset) begin
      bus.mem_ready = 1'b1;
      bus.mem_dout  = '0;
      busy_m        = 1'b0;
      lat_cnt       = 0;
    end else if (bus.mem_rd || bus.mem_we) begin
      if (bus.mem_rd) begin
        rd_log.push_back(bus.mem_addr);
        if (dl_active) rd_during_dl++;
      end else begin
        wr_log.push_back({bus.mem_addr, bus.mem_din});
      end
      pend_addr     = bus.mem_addr;
      bus.mem_ready = 1'b0;
      lat_cnt       = mem_lat;
      busy_m        = 1'b1;
    end else if (busy_m) begin
      lat_cnt--;
      if (lat_cnt <= 0) begin
        bus.mem_ready = 1'b1;
        bus.mem_dout  = PIX_W'(pend_addr >> 1);
        busy_m        = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic drive_idle_inputs();
    dl_active   = 1'b0;
    dl_wr       = 1'b0;
    dl_addr     = '0;
    dl_data     = '0;
    frame_start = 1'b0;
    pix_ce      = 1'b0;
    pix_active  = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive_idle_inputs();
    mem_lat = 3;
    repeat (3) @(negedge clock);
    rd_log.delete();
    wr_log.delete();
    exp_pix.delete();
    exp_wr.delete();
    rd_during_dl = 0;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  task automatic wait_dl_wait_low(input string what);
    int k = 0;
    while (dl_wait === 1'b1 && k < 100) begin
      @(negedge clock);
      k++;
    end
    n_tests++;
    if (k >= 100) begin
      n_fail++;
      $display("FAIL %s: dl_wait=%b after %0d cycles, required 0", what, dl_wait, k);
    end
  endtask

  task automatic test_reset();
    logic [ADDR_W+PIX_W+12:0] outs;
    reset = 1'b1;
    drive_idle_inputs();
    @(negedge clock);
    outs = {dl_wait, pix_data, underrun, overflow, bus.mem_addr, bus.mem_din,
            bus.mem_we, bus.mem_rd};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    apply_reset();
    pix_active = 1'b1;
    repeat (20) @(negedge clock);
    n_tests++;
    if (rd_log.size() !== 0) begin
      n_fail++;
      $display("FAIL no_prefetch_before_frame: %0d reads, required 0", rd_log.size());
    end
  endtask

  task automatic test_stream();
    logic [PIX_W-1:0] exp;
    apply_reset();
    pix_active = 1'b1;
    for (int i = 0; i < 10; i++) exp_pix.push_back(PIX_W'(i));
    pulse_frame_start();
    repeat (60) @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      pix_ce = 1'b1;
      @(posedge clock);
      #1;
      exp = exp_pix.pop_front();
      n_tests++;
      if (pix_data !== exp) begin
        n_fail++;
        $display("FAIL stream_pix[%0d]: got %h, required %h", i, pix_data, exp);
      end
      @(negedge clock);
      pix_ce = 1'b0;
      @(negedge clock);
    end
    n_tests++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_underrun: got %b, required 0", underrun);
    end
    n_tests++;
    if (rd_log.size() < 3) begin
      n_fail++;
      $display("FAIL stream_rd_addrs: %0d reads, required at least 3", rd_log.size());
    end else if ({rd_log[0], rd_log[1], rd_log[2]} !== {25'h0, 25'h2, 25'h4}) begin
      n_fail++;
      $display("FAIL stream_rd_addrs: got %h %h %h, required 0 2 4", rd_log[0], rd_log[1],
               rd_log[2]);
    end
  endtask

  task automatic test_write();
    logic [ADDR_W+7:0] exp;
    apply_reset();
    dl_active = 1'b1;
    @(negedge clock);
    dl_wr = 1'b1; dl_addr = 25'h10; dl_data = 8'hA5;
    exp_wr.push_back({25'h10, 8'hA5});
    @(negedge clock);
    dl_wr = 1'b0;
    n_tests++;
    if (dl_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL write_dl_wait_set: got %b, required 1", dl_wait);
    end
    wait_dl_wait_low("write_first_done");
    dl_wr = 1'b1; dl_addr = 25'h11; dl_data = 8'h5A;
    exp_wr.push_back({25'h11, 8'h5A});
    @(negedge clock);
    dl_wr = 1'b0;
    wait_dl_wait_low("write_second_done");
    repeat (5) @(negedge clock);
    n_tests++;
    if (wr_log.size() !== 2) begin
      n_fail++;
      $display("FAIL write_count: got %0d strobes, required 2", wr_log.size());
    end
    while (exp_wr.size() > 0 && wr_log.size() > 0) begin
      exp = exp_wr.pop_front();
      n_tests++;
      if (wr_log[0] !== exp) begin
        n_fail++;
        $display("FAIL write_addr_din: got %h, required %h", wr_log[0], exp);
      end
      void'(wr_log.pop_front());
    end
    n_tests++;
    if (rd_during_dl !== 0 || rd_log.size() !== 0) begin
      n_fail++;
      $display("FAIL write_no_reads: got %0d reads, required 0", rd_log.size());
    end
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL write_overflow: got %b, required 0", overflow);
    end
    dl_active = 1'b0;
  endtask

  task automatic test_overflow();
    apply_reset();
    dl_active = 1'b1;
    @(negedge clock);
    dl_wr = 1'b1; dl_addr = 25'h20; dl_data = 8'h11;
    exp_wr.push_back({25'h20, 8'h11});
    @(negedge clock);
    dl_addr = 25'h21; dl_data = 8'h22;
    @(negedge clock);
    dl_wr = 1'b0;
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: got %b, required 1", overflow);
    end
    wait_dl_wait_low("overflow_write_done");
    repeat (5) @(negedge clock);
    n_tests++;
    if (wr_log.size() !== 1) begin
      n_fail++;
      $display("FAIL overflow_write_count: got %0d strobes, required 1", wr_log.size());
    end else if (wr_log[0] !== exp_wr[0]) begin
      n_fail++;
      $display("FAIL overflow_kept_byte: got %h, required %h", wr_log[0], exp_wr[0]);
    end
    dl_wr = 1'b1; dl_addr = 25'h30; dl_data = 8'h33;
    @(negedge clock);
    dl_wr = 1'b0;
    wait_dl_wait_low("overflow_later_write");
    repeat (3) @(negedge clock);
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: got %b, required 1", overflow);
    end
    dl_active = 1'b0;
  endtask

  task automatic test_flush();
    logic [PIX_W-1:0] exp;
    int k, base;
    logic found;
    apply_reset();
    pix_active = 1'b1;
    pulse_frame_start();
    k = 0;
    found = 1'b0;
    while (!found && k < 200) begin
      @(negedge clock);
      k++;
      if (bus.mem_rd === 1'b1 && bus.mem_addr === 25'h0E) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL flush_find_read_0e: not seen in %0d cycles, required a read of 0e", k);
    end
    // Read of 0x0E is being strobed right now; flush while it is in flight.
    frame_start = 1'b1;
    exp_pix.delete();
    for (int i = 0; i < 3; i++) exp_pix.push_back(PIX_W'(i));
    @(negedge clock);
    frame_start = 1'b0;
    base = rd_log.size();
    k = 0;
    while (rd_log.size() <= base && k < 100) begin
      @(negedge clock);
      k++;
    end
    n_tests++;
    if (rd_log.size() <= base) begin
      n_fail++;
      $display("FAIL flush_next_read: no read within %0d cycles, required one", k);
    end else if (rd_log[base] !== BaseAddr) begin
      n_fail++;
      $display("FAIL flush_next_read: got addr %h, required %h", rd_log[base], BaseAddr);
    end
    repeat (40) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      pix_ce = 1'b1;
      @(posedge clock);
      #1;
      exp = exp_pix.pop_front();
      n_tests++;
      if (pix_data !== exp) begin
        n_fail++;
        $display("FAIL flush_pix[%0d]: got %h, required %h", i, pix_data, exp);
      end
      @(negedge clock);
      pix_ce = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic test_underrun();
    logic [PIX_W-1:0] exp;
    apply_reset();
    pix_active = 1'b1;
    pulse_frame_start();
    repeat (60) @(negedge clock);
    mem_lat = 40;
    for (int i = 0; i < 8; i++) exp_pix.push_back(PIX_W'(i));
    for (int i = 0; i < 4; i++) exp_pix.push_back('0);
    pix_ce = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1;
      exp = exp_pix.pop_front();
      n_tests++;
      if (pix_data !== exp) begin
        n_fail++;
        $display("FAIL underrun_pix[%0d]: got %h, required %h", i, pix_data, exp);
      end
      if (i == 7) begin
        n_tests++;
        if (underrun !== 1'b0) begin
          n_fail++;
          $display("FAIL underrun_early: got %b, required 0", underrun);
        end
      end
    end
    @(negedge clock);
    pix_ce = 1'b0;
    repeat (3) @(negedge clock);
    n_tests++;
    if (underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_sticky: got %b, required 1", underrun);
    end
  endtask

  task automatic test_reset_mid();
    logic [ADDR_W+PIX_W+12:0] outs;
    int k;
    apply_reset();
    mem_lat = 40;
    pulse_frame_start();
    repeat (60) @(negedge clock);
    n_tests++;
    if (bus.mem_addr !== 25'h2) begin
      n_fail++;
      $display("FAIL reset_mid_busy_addr: got %h, required 2", bus.mem_addr);
    end
    reset = 1'b1;
    #1;
    outs = {dl_wait, pix_data, underrun, overflow, bus.mem_addr, bus.mem_din,
            bus.mem_we, bus.mem_rd};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h, required 0", outs);
    end
    @(negedge clock);
    @(negedge clock);
    rd_log.delete();
    mem_lat = 3;
    reset = 1'b0;
    @(negedge clock);
    pulse_frame_start();
    k = 0;
    while (rd_log.size() == 0 && k < 50) begin
      @(negedge clock);
      k++;
    end
    n_tests++;
    if (rd_log.size() == 0) begin
      n_fail++;
      $display("FAIL reset_mid_restart: no read within %0d cycles, required one", k);
    end else if (rd_log[0] !== BaseAddr) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got addr %h, required %h", rd_log[0], BaseAddr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_write();
    test_overflow();
    test_flush();
    test_underrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
